// File: rtl/pow5_root_iter.sv
// Integer fifth root floor(x^(1/5)) of a 5*W-bit operand: restoring, MSB first, one shared W x 5W multiplier.
// Latency 6*W cycles accept-to-result; in_ready only in IDLE; the result holds until out_ready.
module pow5_root_iter #(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5*W-1:0]   in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_root,
    output logic             out_exact
);

    localparam int XW = 5 * W;
    localparam int BW = $clog2(W);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_MUL  = 3'd2;
    localparam logic [2:0] S_CMP  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    generate
        if ((W < 2) || (W > 8)) begin : g_bad_w
            $error("pow5_root_iter: W must be in 2..8");
        end
    endgenerate

    logic [2:0]    state_q,     state_d;
    logic [XW-1:0] x_q,         x_d;
    logic [XW-1:0] acc_q,       acc_d;
    logic [XW-1:0] best_q,      best_d;
    logic [W-1:0]  root_q,      root_d;
    logic [W-1:0]  trial_q,     trial_d;
    logic [BW-1:0] b_q,         b_d;
    logic [1:0]    mcnt_q,      mcnt_d;
    logic [W-1:0]  out_root_q,  out_root_d;
    logic          out_exact_q, out_exact_d;

    logic [XW-1:0] prod;
    logic          take;
    logic [W-1:0]  root_nxt;
    logic [XW-1:0] best_nxt;

    // trial < 2^W, so trial^5 never exceeds XW bits and truncation is lossless
    assign prod     = acc_q * {{(XW-W){1'b0}}, trial_q};
    assign take     = (acc_q <= x_q);
    assign root_nxt = take ? trial_q : root_q;
    assign best_nxt = take ? acc_q : best_q;

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        acc_d       = acc_q;
        best_d      = best_q;
        root_d      = root_q;
        trial_d     = trial_q;
        b_d         = b_q;
        mcnt_d      = mcnt_q;
        out_root_d  = out_root_q;
        out_exact_d = out_exact_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    x_d     = in_data;
                    root_d  = '0;
                    best_d  = '0;
                    b_d     = BW'(W - 1);
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                trial_d = root_q | (W'(1) << b_q);
                acc_d   = {{(XW-W){1'b0}}, root_q | (W'(1) << b_q)};
                mcnt_d  = '0;
                state_d = S_MUL;
            end
            S_MUL: begin
                acc_d  = prod;
                mcnt_d = mcnt_q + 2'd1;
                if (mcnt_q == 2'd3) begin
                    state_d = S_CMP;
                end
            end
            S_CMP: begin
                root_d = root_nxt;
                best_d = best_nxt;
                if (b_q == '0) begin
                    out_root_d  = root_nxt;
                    out_exact_d = (best_nxt == x_q);
                    state_d     = S_DONE;
                end else begin
                    b_d     = b_q - 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            acc_q       <= '0;
            best_q      <= '0;
            root_q      <= '0;
            trial_q     <= '0;
            b_q         <= '0;
            mcnt_q      <= '0;
            out_root_q  <= '0;
            out_exact_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            acc_q       <= acc_d;
            best_q      <= best_d;
            root_q      <= root_d;
            trial_q     <= trial_d;
            b_q         <= b_d;
            mcnt_q      <= mcnt_d;
            out_root_q  <= out_root_d;
            out_exact_q <= out_exact_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out_root  = out_root_q;
    assign out_exact = out_exact_q;

endmodule
